// File: rtl/gx_rst_ctrl_x3.sv
// -----------------------------------------------------------------------------
// gx_rst_ctrl_x3
//
// Per-channel reset sequencer for a 3-channel standard-PCS transceiver bank.
// Each channel has one TX FSM (ANA -> DIG -> RDY) and one RX FSM
// (ANA -> LTD -> RDY). All of them run on the free-running management clock
// and are sequenced against PLL lock, calibration-busy and CDR lock-to-data.
//
// Optional build macro:
//   GX_RST_LTD_TIMEOUT_EN - adds a per-channel RX timeout counter in LTD. When
//                           it reaches T_TIMEOUT-1 the RX FSM goes back to ANA,
//                           which forces a CDR re-lock through analog reset.
//                           When undefined, LTD waits for lock indefinitely and
//                           T_TIMEOUT has no effect.
//
// Ports:
//   reconfig_clk        in   management clock
//   reconfig_reset_n    in   synchronous active-low reset
//   pll_locked          in   TX PLL lock (asynchronous)
//   tx_reset_req        in   [NUM_CH] per-channel TX restart request (level)
//   rx_reset_req        in   [NUM_CH] per-channel RX restart request (level)
//   tx_cal_busy         in   [NUM_CH] TX calibration busy (asynchronous)
//   rx_cal_busy         in   [NUM_CH] RX calibration busy (asynchronous)
//   rx_is_lockedtodata  in   [NUM_CH] CDR locked to data (asynchronous)
//   tx_analogreset      out  [NUM_CH] to transceiver
//   tx_digitalreset     out  [NUM_CH] to transceiver
//   rx_analogreset      out  [NUM_CH] to transceiver
//   rx_digitalreset     out  [NUM_CH] to transceiver
//   tx_ready            out  [NUM_CH] TX channel operational
//   rx_ready            out  [NUM_CH] RX channel operational
// -----------------------------------------------------------------------------
module gx_rst_ctrl_x3 #(
    parameter int NUM_CH    = 3,
    parameter int T_ANALOG  = 1000,
    parameter int T_DIGITAL = 500,
    parameter int T_LTD     = 2000,
    parameter int T_TIMEOUT = 200000
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset_n,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] tx_reset_req,
    input  logic [NUM_CH-1:0] rx_reset_req,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic [NUM_CH-1:0] tx_ready,
    output logic [NUM_CH-1:0] rx_ready
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef GX_RST_LTD_TIMEOUT_EN
    localparam int T_MAX = max2(max2(T_ANALOG, T_DIGITAL), max2(T_LTD, T_TIMEOUT));
`else
    localparam int T_MAX = max2(max2(T_ANALOG, T_DIGITAL), T_LTD);
`endif
    localparam int CW = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

    localparam logic [CW-1:0] TA_LAST = CW'(T_ANALOG - 1);
    localparam logic [CW-1:0] TD_LAST = CW'(T_DIGITAL - 1);
    localparam logic [CW-1:0] TL_LAST = CW'(T_LTD - 1);

    typedef enum logic [1:0] {TX_ANA, TX_DIG, TX_RDY} tx_state_t;
    typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_RDY} rx_state_t;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // 2-flop synchronizers. Calibration status is carried as active-high
    // "idle", so a freshly cleared synchronizer reads as "still calibrating"
    // and no FSM starts counting before real status has propagated through.
    // -------------------------------------------------------------------------
    logic              pll_meta_reg;
    logic              pll_sync_reg;
    logic [NUM_CH-1:0] tx_idle_meta_reg;
    logic [NUM_CH-1:0] tx_idle_sync_reg;
    logic [NUM_CH-1:0] rx_idle_meta_reg;
    logic [NUM_CH-1:0] rx_idle_sync_reg;
    logic [NUM_CH-1:0] ltd_meta_reg;
    logic [NUM_CH-1:0] ltd_sync_reg;

    always_ff @(posedge reconfig_clk) begin
        if (!reconfig_reset_n) begin
            pll_meta_reg     <= 1'b0;
            pll_sync_reg     <= 1'b0;
            tx_idle_meta_reg <= '0;
            tx_idle_sync_reg <= '0;
            rx_idle_meta_reg <= '0;
            rx_idle_sync_reg <= '0;
            ltd_meta_reg     <= '0;
            ltd_sync_reg     <= '0;
        end else begin
            pll_meta_reg     <= pll_locked;
            pll_sync_reg     <= pll_meta_reg;
            tx_idle_meta_reg <= ~tx_cal_busy;
            tx_idle_sync_reg <= tx_idle_meta_reg;
            rx_idle_meta_reg <= ~rx_cal_busy;
            rx_idle_sync_reg <= rx_idle_meta_reg;
            ltd_meta_reg     <= rx_is_lockedtodata;
            ltd_sync_reg     <= ltd_meta_reg;
        end
    end

`ifndef GX_RST_LTD_TIMEOUT_EN
    // T_TIMEOUT only matters when the LTD timeout is built in.
    if (T_TIMEOUT < 1) begin : g_t_timeout_unused
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // ---------------------------------------------------------------
            // TX FSM
            // ---------------------------------------------------------------
            tx_state_t      tx_state_reg, tx_state_next;
            logic [CW-1:0]  tx_cnt_reg, tx_cnt_next;
            logic           tx_ana_reg, tx_dig_reg, tx_rdy_reg;

            always_comb begin
                tx_state_next = tx_state_reg;
                tx_cnt_next   = tx_cnt_reg;
                if (tx_reset_req[gi]) begin
                    tx_state_next = TX_ANA;
                    tx_cnt_next   = '0;
                end else begin
                    case (tx_state_reg)
                        TX_ANA: begin
                            if (tx_idle_sync_reg[gi] && pll_sync_reg) begin
                                if (tx_cnt_reg == TA_LAST) begin
                                    tx_state_next = TX_DIG;
                                    tx_cnt_next   = '0;
                                end else begin
                                    tx_cnt_next = sat_inc(tx_cnt_reg);
                                end
                            end else begin
                                tx_cnt_next = '0;
                            end
                        end
                        TX_DIG: begin
                            if (!tx_idle_sync_reg[gi]) begin
                                tx_state_next = TX_ANA;
                                tx_cnt_next   = '0;
                            end else if (!pll_sync_reg) begin
                                tx_cnt_next = '0;
                            end else if (tx_cnt_reg == TD_LAST) begin
                                tx_state_next = TX_RDY;
                                tx_cnt_next   = '0;
                            end else begin
                                tx_cnt_next = sat_inc(tx_cnt_reg);
                            end
                        end
                        TX_RDY: begin
                            if (!tx_idle_sync_reg[gi]) begin
                                tx_state_next = TX_ANA;
                                tx_cnt_next   = '0;
                            end else if (!pll_sync_reg) begin
                                tx_state_next = TX_DIG;
                                tx_cnt_next   = '0;
                            end
                        end
                        default: begin
                            tx_state_next = TX_ANA;
                            tx_cnt_next   = '0;
                        end
                    endcase
                end
            end

            // Resets follow the next state; ready additionally needs a full
            // cycle in RDY, so it rises one cycle after digital reset falls.
            always_ff @(posedge reconfig_clk) begin
                if (!reconfig_reset_n) begin
                    tx_state_reg <= TX_ANA;
                    tx_cnt_reg   <= '0;
                    tx_ana_reg   <= 1'b1;
                    tx_dig_reg   <= 1'b1;
                    tx_rdy_reg   <= 1'b0;
                end else begin
                    tx_state_reg <= tx_state_next;
                    tx_cnt_reg   <= tx_cnt_next;
                    tx_ana_reg   <= (tx_state_next == TX_ANA);
                    tx_dig_reg   <= (tx_state_next != TX_RDY);
                    tx_rdy_reg   <= (tx_state_reg == TX_RDY) && (tx_state_next == TX_RDY);
                end
            end

            assign tx_analogreset[gi]  = tx_ana_reg;
            assign tx_digitalreset[gi] = tx_dig_reg;
            assign tx_ready[gi]        = tx_rdy_reg;

            // ---------------------------------------------------------------
            // RX FSM
            // ---------------------------------------------------------------
            rx_state_t      rx_state_reg, rx_state_next;
            logic [CW-1:0]  rx_cnt_reg, rx_cnt_next;
            logic           rx_ana_reg, rx_dig_reg, rx_rdy_reg;
            logic           rx_timeout_hit;

`ifdef GX_RST_LTD_TIMEOUT_EN
            localparam logic [CW-1:0] TO_LAST = CW'(T_TIMEOUT - 1);
            logic [CW-1:0] rx_to_reg, rx_to_next;

            // Runs for as long as the FSM stays in LTD, regardless of lock.
            assign rx_timeout_hit = (rx_to_reg == TO_LAST);

            always_comb begin
                rx_to_next = '0;
                if ((rx_state_reg == RX_LTD) && (rx_state_next == RX_LTD)) begin
                    rx_to_next = sat_inc(rx_to_reg);
                end
            end

            always_ff @(posedge reconfig_clk) begin
                if (!reconfig_reset_n) begin
                    rx_to_reg <= '0;
                end else begin
                    rx_to_reg <= rx_to_next;
                end
            end
`else
            assign rx_timeout_hit = 1'b0;
`endif

            always_comb begin
                rx_state_next = rx_state_reg;
                rx_cnt_next   = rx_cnt_reg;
                if (rx_reset_req[gi]) begin
                    rx_state_next = RX_ANA;
                    rx_cnt_next   = '0;
                end else begin
                    case (rx_state_reg)
                        RX_ANA: begin
                            if (rx_idle_sync_reg[gi]) begin
                                if (rx_cnt_reg == TA_LAST) begin
                                    rx_state_next = RX_LTD;
                                    rx_cnt_next   = '0;
                                end else begin
                                    rx_cnt_next = sat_inc(rx_cnt_reg);
                                end
                            end else begin
                                rx_cnt_next = '0;
                            end
                        end
                        RX_LTD: begin
                            if (!rx_idle_sync_reg[gi] || rx_timeout_hit) begin
                                rx_state_next = RX_ANA;
                                rx_cnt_next   = '0;
                            end else if (!ltd_sync_reg[gi]) begin
                                rx_cnt_next = '0;
                            end else if (rx_cnt_reg == TL_LAST) begin
                                rx_state_next = RX_RDY;
                                rx_cnt_next   = '0;
                            end else begin
                                rx_cnt_next = sat_inc(rx_cnt_reg);
                            end
                        end
                        RX_RDY: begin
                            if (!rx_idle_sync_reg[gi]) begin
                                rx_state_next = RX_ANA;
                                rx_cnt_next   = '0;
                            end else if (!ltd_sync_reg[gi]) begin
                                rx_state_next = RX_LTD;
                                rx_cnt_next   = '0;
                            end
                        end
                        default: begin
                            rx_state_next = RX_ANA;
                            rx_cnt_next   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge reconfig_clk) begin
                if (!reconfig_reset_n) begin
                    rx_state_reg <= RX_ANA;
                    rx_cnt_reg   <= '0;
                    rx_ana_reg   <= 1'b1;
                    rx_dig_reg   <= 1'b1;
                    rx_rdy_reg   <= 1'b0;
                end else begin
                    rx_state_reg <= rx_state_next;
                    rx_cnt_reg   <= rx_cnt_next;
                    rx_ana_reg   <= (rx_state_next == RX_ANA);
                    rx_dig_reg   <= (rx_state_next != RX_RDY);
                    rx_rdy_reg   <= (rx_state_reg == RX_RDY) && (rx_state_next == RX_RDY);
                end
            end

            assign rx_analogreset[gi]  = rx_ana_reg;
            assign rx_digitalreset[gi] = rx_dig_reg;
            assign rx_ready[gi]        = rx_rdy_reg;
        end
    endgenerate

endmodule

// File: doc/gx_rst_ctrl_x3.md
Name: gx_rst_ctrl_x3

Overview:
Per-channel reset sequencer that drives the analog and digital reset inputs of the 3-channel standard-PCS transceiver bank.
- Runs one TX FSM and one RX FSM per channel, both clocked by the free-running management clock.
- Sequences the resets against PLL lock, calibration-busy and CDR lock-to-data status.
- Asserts per-channel tx_ready/rx_ready, which the GBT TX/RX datapath uses to qualify its parallel data.

Parameters:
- NUM_CH, 3, number of transceiver channels.
- T_ANALOG, 1000, minimum cycles analog reset is held after calibration and PLL conditions are met.
- T_DIGITAL, 500, cycles TX digital reset is held after TX analog release with pll_locked stable.
- T_LTD, 2000, cycles rx_is_lockedtodata must be continuously high before RX digital release.
- T_TIMEOUT, 200000, RX lock-to-data timeout in cycles (optional feature only).

Ports:
- reconfig_clk  in  1  free-running management clock.
- reconfig_reset_n  in  1  synchronous active-low reset.
- pll_locked  in  1  TX PLL lock, asynchronous.
- tx_reset_req  in  NUM_CH  per-channel TX restart request, sync, level.
- rx_reset_req  in  NUM_CH  per-channel RX restart request, sync, level.
- tx_cal_busy  in  NUM_CH  from transceiver, asynchronous.
- rx_cal_busy  in  NUM_CH  from transceiver, asynchronous.
- rx_is_lockedtodata  in  NUM_CH  from transceiver, asynchronous.
- tx_analogreset  out  NUM_CH  to transceiver.
- tx_digitalreset  out  NUM_CH  to transceiver.
- rx_analogreset  out  NUM_CH  to transceiver.
- rx_digitalreset  out  NUM_CH  to transceiver.
- tx_ready  out  NUM_CH  TX channel operational.
- rx_ready  out  NUM_CH  RX channel operational.

Behaviour:
- Synchronizers: all asynchronous inputs pass through a 2-flop synchronizer (reset value 0). Latency adds 2 cycles to every status-driven transition. Every condition below refers to the synchronized value.
- Registered outputs only. Under reconfig_reset_n=0, all analog and digital resets = 1, ready = 0, FSMs go to ANA, counters = 0, synchronizers = 0.
- TX FSM, per channel:
  - ANA: tx_analogreset=1, tx_digitalreset=1. Counter increments each cycle that tx_cal_busy=0 and pll_locked=1; it clears otherwise. When counter = T_ANALOG-1 with the condition true, go to DIG.
  - DIG: tx_analogreset=0, tx_digitalreset=1. Counter increments while pll_locked=1 and clears when pll_locked=0. When counter = T_DIGITAL-1, go to RDY.
  - RDY: both resets 0, tx_ready=1. If pll_locked=0, go to DIG with counter cleared and tx_ready=0 on the next cycle.
- RX FSM, per channel:
  - ANA: rx_analogreset=1, rx_digitalreset=1. Counter increments while rx_cal_busy=0. When counter = T_ANALOG-1, go to LTD.
  - LTD: rx_analogreset=0, rx_digitalreset=1. Counter increments while rx_is_lockedtodata=1 and clears on 0. When counter = T_LTD-1, go to RDY.
  - RDY: both resets 0, rx_ready=1. If rx_is_lockedtodata=0, go to LTD with counter cleared.
- Every counter clears on every state entry. Counter width = clog2 of the largest T parameter in use, and counters saturate, never wrap.
- Priority (highest first): reconfig_reset_n, then *_reset_req, then the state condition. A request held high keeps the channel in ANA with the counter at 0. The sequence restarts on the cycle after the request drops.
- Any calibration restart (cal_busy=1) in DIG, LTD or RDY returns that FSM to ANA.
- TX and RX FSMs are fully independent across directions and across channels.
- Minimum latency from release to ready:
  - TX: 2+T_ANALOG+T_DIGITAL+1 cycles.
  - RX: 2+T_ANALOG+T_LTD+1 cycles.

Optional Feature:
GX_RST_LTD_TIMEOUT_EN
- Defined: each RX channel has a second counter that runs while in LTD and never clears on lock loss. When it reaches T_TIMEOUT-1, the FSM returns to ANA, forcing a CDR re-lock through analog reset. The counter clears on leaving LTD.
- Undefined: no timeout counter exists, T_TIMEOUT is unused, and LTD waits indefinitely.

Test Plan:
Parameters for all scenarios: T_ANALOG=4, T_DIGITAL=4, T_LTD=8, T_TIMEOUT=32.
1. Reset release with pll_locked=1, cal_busy=0, lockedtodata=1 -> tx_analogreset falls at cycle 6, tx_digitalreset at 10, tx_ready=1 at 11; rx_ready=1 at 15, all channels.
2. tx_cal_busy[1] held 1 for 20 cycles after reset -> channel 1 TX stays in ANA, then releases 6 cycles after cal_busy drops. Channels 0 and 2 are unaffected.
3. Channel 2 in RDY, rx_is_lockedtodata[2] pulses low 1 cycle -> rx_digitalreset[2]=1 and rx_ready[2]=0 at cycle +3; ready again 8 cycles after the re-lock is synchronized.
4. pll_locked drops in RDY -> all tx_digitalreset=1 and tx_ready=0, tx_analogreset stays 0; recovery T_DIGITAL cycles after re-lock.
5. rx_reset_req[0] asserted mid-LTD and simultaneously with lock loss -> channel 0 goes to ANA (request wins), and the sequence restarts when the request drops.
6. With GX_RST_LTD_TIMEOUT_EN and lockedtodata stuck at 0 -> rx_analogreset re-asserts after 32 cycles in LTD, repeating. Without the macro -> the channel stays in LTD forever.
